// File: rtl/lbirow_row_loader.sv
// Packs WORD_W-bit words into ROW_W-bit Lbirow rows with frame tracking; optional rand_out LFSR under LBIROW_LOADER_LFSR_EN.
// row_valid one cycle after a row's last word; in_ready drops for MIN_GAP cycles after each row (Lbirow cannot stall).
module lbirow_row_loader #(
    parameter int          WORD_W         = 24,
    parameter int          ROW_W          = 840,
    parameter int          WORDS          = 35,
    parameter int          ROWS_PER_FRAME = 16,
    parameter int          MIN_GAP        = 1,
    parameter logic [95:0] SEED           = 96'h1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_sof_i,
    output logic              in_ready_o,
    output logic [ROW_W-1:0]  row_out_o,
    output logic              row_valid_o,
    output logic              row_start_o,
    output logic [95:0]       rand_out_o,
    output logic              frame_done_o,
    output logic              err_sof_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int WC_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RC_W = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam int ACC_W = ROW_W - WORD_W;

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(ROWS_PER_FRAME - 1);
    localparam logic [3:0]      GAP_LAST  = 4'(MIN_GAP - 1);

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [RC_W-1:0]  row_cnt_q, row_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_valid_q, row_valid_d;
    logic             row_start_q, row_start_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic             accept;

    // Words shift in at the LSB end, so word 0 ends up in the MSBs once the row is full.
    logic [ACC_W-1:0] acc_shift;
    assign acc_shift  = {acc_q[ACC_W-WORD_W-1:0], in_data_i};
    assign in_ready_o = (state_q != ST_GAP);
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        row_cnt_d    = row_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        acc_d        = acc_q;
        row_d        = row_q;
        row_valid_d  = 1'b0;
        row_start_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_sof_i) begin
                    acc_d      = acc_shift;
                    word_cnt_d = WC_W'(1);
                    row_cnt_d  = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    acc_d = acc_shift;
                    if (in_sof_i) begin
                        err_d      = 1'b1;
                        word_cnt_d = WC_W'(1);
                        row_cnt_d  = '0;
                    end else if (word_cnt_q == LAST_WORD) begin
                        row_d        = {acc_q, in_data_i};
                        row_valid_d  = 1'b1;
                        row_start_d  = (row_cnt_q == '0);
                        frame_done_d = (row_cnt_q == LAST_ROW);
                        word_cnt_d   = '0;
                        row_cnt_d    = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + RC_W'(1);
                        if (MIN_GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else if (row_cnt_q == LAST_ROW) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = (row_cnt_q == '0) ? ST_IDLE : ST_FILL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            row_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            acc_q        <= '0;
            row_q        <= '0;
            row_valid_q  <= 1'b0;
            row_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            row_cnt_q    <= row_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            acc_q        <= acc_d;
            row_q        <= row_d;
            row_valid_q  <= row_valid_d;
            row_start_q  <= row_start_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign row_out_o    = row_q;
    assign row_valid_o  = row_valid_q;
    assign row_start_o  = row_start_q;
    assign frame_done_o = frame_done_q;
    assign err_sof_o    = err_q;

`ifdef LBIROW_LOADER_LFSR_EN
    // Advances on the cycle after row_valid so each row sees a fresh value.
    logic [95:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[94:0], lfsr_q[95] ^ lfsr_q[93] ^ lfsr_q[48] ^ lfsr_q[46]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else if (row_valid_q) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_out_o = lfsr_q;
`else
    assign rand_out_o = '0;
`endif

endmodule

// File: tb/tb_lbirow_row_loader.sv
// Randomized bench for lbirow_row_loader against a word-list/frame reference model.
module tb_lbirow_row_loader;

    localparam int          WORD_W  = 24;
    localparam int          ROW_W   = 840;
    localparam int          WORDS   = 35;
    localparam int          RPF     = 16;
    localparam logic [95:0] SEED    = 96'h1;

`ifdef LBIROW_LOADER_LFSR_EN
    localparam logic [95:0] RST_RAND = SEED;
    localparam logic [95:0] RND0 = 96'h1;
    localparam logic [95:0] RND1 = 96'h2;
    localparam logic [95:0] RND2 = 96'h4;
`else
    localparam logic [95:0] RST_RAND = '0;
    localparam logic [95:0] RND0 = '0;
    localparam logic [95:0] RND1 = '0;
    localparam logic [95:0] RND2 = '0;
`endif

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic             start;
        logic             done;
        logic [95:0]      rnd;
    } rowrec_t;

    logic              clk;
    logic              rst_n;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic [ROW_W-1:0]  row_out;
    logic              row_valid;
    logic              row_start;
    logic [95:0]       rand_out;
    logic              frame_done;
    logic              err_sof;

    lbirow_row_loader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_sof_i     (in_sof),
        .in_ready_o   (in_ready),
        .row_out_o    (row_out),
        .row_valid_o  (row_valid),
        .row_start_o  (row_start),
        .rand_out_o   (rand_out),
        .frame_done_o (frame_done),
        .err_sof_o    (err_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: current frame as a list of words, row index within the frame.
    logic [WORD_W-1:0] cur_words[$];
    bit                m_in_frame;
    int                m_row_idx;
    bit                m_err;
    logic [95:0]       m_lfsr;
    rowrec_t           exp_q[$];
    rowrec_t           obs_q[$];

    task automatic model_reset();
        cur_words.delete();
        m_in_frame = 0;
        m_row_idx  = 0;
        m_err      = 0;
        m_lfsr     = SEED;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_accept(input logic [WORD_W-1:0] d, input logic sof);
        rowrec_t r;
        if (sof) begin
            if (m_in_frame) m_err = 1;
            cur_words.delete();
            cur_words.push_back(d);
            m_in_frame = 1;
            m_row_idx  = 0;
        end else if (m_in_frame) begin
            cur_words.push_back(d);
            if (cur_words.size() == WORDS) begin
                r.row = '0;
                foreach (cur_words[k]) r.row[ROW_W-1-k*WORD_W -: WORD_W] = cur_words[k];
                r.start = (m_row_idx == 0);
                r.done  = (m_row_idx == RPF - 1);
`ifdef LBIROW_LOADER_LFSR_EN
                r.rnd  = m_lfsr;
                m_lfsr = {m_lfsr[94:0], m_lfsr[95] ^ m_lfsr[93] ^ m_lfsr[48] ^ m_lfsr[46]};
`else
                r.rnd  = '0;
`endif
                exp_q.push_back(r);
                cur_words.delete();
                m_row_idx++;
                if (m_row_idx == RPF) begin
                    m_row_idx  = 0;
                    m_in_frame = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        rowrec_t o;
        if (rst_n && row_valid) begin
            o.row   = row_out;
            o.start = row_start;
            o.done  = frame_done;
            o.rnd   = rand_out;
            obs_q.push_back(o);
        end
    end

    task automatic send_word(input logic [WORD_W-1:0] d, input logic sof, input int max_bubble);
        int guard;
        bit acc;
        repeat ($urandom_range(max_bubble, 0)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
        guard = 0;
        acc   = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_sof   = sof;
            acc      = in_ready;
            @(posedge clk);
            guard++;
        end
        if (acc) begin
            model_accept(d, sof);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 64 cycles", in_ready);
        end
    endtask

    task automatic send_row(input logic first_sof, input int max_bubble);
        for (int w = 0; w < WORDS; w++) send_word(WORD_W'($urandom), first_sof && (w == 0), max_bubble);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++; if (row_valid !== 1'b0)  begin failures++; $display("FAIL reset_row_valid: got %b, required 0", row_valid); end
        checks++; if (row_start !== 1'b0)  begin failures++; $display("FAIL reset_row_start: got %b, required 0", row_start); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        checks++; if (err_sof !== 1'b0)    begin failures++; $display("FAIL reset_err_sof: got %b, required 0", err_sof); end
        checks++; if (row_out !== '0)      begin failures++; $display("FAIL reset_row_out: got nonzero, required 0"); end
        checks++; if (rand_out !== RST_RAND) begin failures++; $display("FAIL reset_rand_out: got %h, required %h", rand_out, RST_RAND); end
        rst_n = 1'b1;
    endtask

    task automatic test_first_row();
        for (int w = 0; w < WORDS; w++) send_word(WORD_W'(w + 1), w == 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (row_valid !== 1'b1) begin failures++; $display("FAIL first_row_valid: got %b, required 1", row_valid); end
        checks++; if (row_start !== 1'b1) begin failures++; $display("FAIL first_row_start: got %b, required 1", row_start); end
        checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL first_gap_ready: got %b, required 0", in_ready); end
        checks++; if (row_out[ROW_W-1 -: WORD_W] !== 24'h000001) begin failures++; $display("FAIL first_row_msb: got %h, required 000001", row_out[ROW_W-1 -: WORD_W]); end
        checks++; if (row_out[WORD_W-1:0] !== 24'h000023) begin failures++; $display("FAIL first_row_lsb: got %h, required 000023", row_out[WORD_W-1:0]); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL first_gap_end: in_ready got %b, required 1", in_ready); end
        checks++; if (row_valid !== 1'b0) begin failures++; $display("FAIL first_row_pulse: row_valid got %b, required 0", row_valid); end
        idle(3);
        checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL first_row_model: got %0d rows, required %0d matching rows", obs_q.size(), exp_q.size());
        end
        checks++; if (row_out !== exp_q[0].row) begin failures++; $display("FAIL first_row_hold: row_out changed after pulse"); end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int r = 0; r < RPF; r++) send_row(r == 0, 0);
        idle(4);
        checks++; if (obs_q.size() != RPF) begin failures++; $display("FAIL full_frame_count: got %0d rows, required %0d", obs_q.size(), RPF); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL full_frame_row%0d: got hi=%h mid=%h lo=%h st=%b fd=%b rnd=%h, required hi=%h mid=%h lo=%h st=%b fd=%b rnd=%h", i,
                         obs_q[i].row[ROW_W-1 -: 24], obs_q[i].row[431:408], obs_q[i].row[23:0], obs_q[i].start, obs_q[i].done, obs_q[i].rnd,
                         exp_q[i].row[ROW_W-1 -: 24], exp_q[i].row[431:408], exp_q[i].row[23:0], exp_q[i].start, exp_q[i].done, exp_q[i].rnd);
            end
        end
        if (obs_q.size() >= 3) begin
            checks++; if (obs_q[0].rnd !== RND0) begin failures++; $display("FAIL rand_row0: got %h, required %h", obs_q[0].rnd, RND0); end
            checks++; if (obs_q[1].rnd !== RND1) begin failures++; $display("FAIL rand_row1: got %h, required %h", obs_q[1].rnd, RND1); end
            checks++; if (obs_q[2].rnd !== RND2) begin failures++; $display("FAIL rand_row2: got %h, required %h", obs_q[2].rnd, RND2); end
        end
        exp_q.delete();
        obs_q.delete();
        // Back in IDLE: stray non-sof words are dropped and a new sof is not an error.
        for (int i = 0; i < 5; i++) send_word(WORD_W'($urandom), 1'b0, 0);
        send_row(1'b1, 1);
        idle(4);
        checks++; if (err_sof !== 1'b0) begin failures++; $display("FAIL frame_idle_err: got %b, required 0", err_sof); end
        checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].start !== 1'b1) begin
            failures++; $display("FAIL frame_idle_next: got %0d rows, required 1 matching row with row_start", obs_q.size());
        end
    endtask

    task automatic test_sof_error();
        logic [WORD_W-1:0] sof_word;
        do_reset();
        for (int r = 0; r < 3; r++) send_row(r == 0, 1);
        for (int w = 0; w < 10; w++) send_word(WORD_W'($urandom), 1'b0, 1);
        sof_word = WORD_W'($urandom);
        send_word(sof_word, 1'b1, 0);
        for (int w = 1; w < WORDS; w++) send_word(WORD_W'($urandom), 1'b0, 1);
        idle(4);
        checks++; if (err_sof !== 1'b1) begin failures++; $display("FAIL sof_err_set: got %b, required 1", err_sof); end
        checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL sof_err_count: got %0d rows, required 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL sof_err_row%0d: got hi=%h lo=%h st=%b fd=%b, required hi=%h lo=%h st=%b fd=%b", i,
                         obs_q[i].row[ROW_W-1 -: 24], obs_q[i].row[23:0], obs_q[i].start, obs_q[i].done,
                         exp_q[i].row[ROW_W-1 -: 24], exp_q[i].row[23:0], exp_q[i].start, exp_q[i].done);
            end
        end
        if (obs_q.size() == 4) begin
            checks++; if (obs_q[3].start !== 1'b1 || obs_q[3].row[ROW_W-1 -: WORD_W] !== sof_word) begin
                failures++; $display("FAIL sof_err_restart: got st=%b hi=%h, required st=1 hi=%h", obs_q[3].start, obs_q[3].row[ROW_W-1 -: WORD_W], sof_word);
            end
        end
        idle(10);
        checks++; if (err_sof !== 1'b1) begin failures++; $display("FAIL sof_err_sticky: got %b, required 1", err_sof); end
    endtask

    task automatic test_idle_drop();
        do_reset();
        for (int i = 0; i < 20; i++) send_word(WORD_W'($urandom), 1'b0, 1);
        idle(4);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL idle_drop_rows: got %0d rows, required 0", obs_q.size()); end
        checks++; if (err_sof !== 1'b0)  begin failures++; $display("FAIL idle_drop_err: got %b, required 0", err_sof); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_drop_ready: got %b, required 1", in_ready); end
        checks++; if (row_out !== '0)    begin failures++; $display("FAIL idle_drop_row_out: got nonzero, required 0"); end
    endtask

    task automatic test_reset_mid_row();
        do_reset();
        send_row(1'b1, 0);
        for (int w = 0; w < 10; w++) send_word(WORD_W'($urandom), 1'b0, 0);
        send_word(WORD_W'($urandom), 1'b1, 0);
        for (int w = 1; w < 20; w++) send_word(WORD_W'($urandom), 1'b0, 0);
        checks++; if (err_sof !== 1'b1 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL midrst_pre: got err=%b rows=%0d, required err=1 and 1 matching row", err_sof, obs_q.size());
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (row_out !== '0)        begin failures++; $display("FAIL midrst_row_out: got nonzero, required 0"); end
        checks++; if (err_sof !== 1'b0)      begin failures++; $display("FAIL midrst_err: got %b, required 0", err_sof); end
        checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL midrst_ready: got %b, required 1", in_ready); end
        checks++; if (rand_out !== RST_RAND) begin failures++; $display("FAIL midrst_rand: got %h, required %h", rand_out, RST_RAND); end
        checks++; if (row_valid !== 1'b0 || row_start !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL midrst_pulses: got v=%b s=%b d=%b, required 0 0 0", row_valid, row_start, frame_done);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        send_row(1'b1, 1);
        idle(4);
        checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].start !== 1'b1) begin
            failures++; $display("FAIL midrst_next_row: got %0d rows, required 1 matching row with row_start", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 1500; i++) send_word(WORD_W'($urandom), (i == 0) || ($urandom_range(199, 0) == 0), 2);
        idle(6);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d rows, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_row%0d: got hi=%h lo=%h st=%b fd=%b rnd=%h, required hi=%h lo=%h st=%b fd=%b rnd=%h", i,
                         obs_q[i].row[ROW_W-1 -: 24], obs_q[i].row[23:0], obs_q[i].start, obs_q[i].done, obs_q[i].rnd,
                         exp_q[i].row[ROW_W-1 -: 24], exp_q[i].row[23:0], exp_q[i].start, exp_q[i].done, exp_q[i].rnd);
            end
        end
        checks++; if (err_sof !== m_err) begin failures++; $display("FAIL random_err: got %b, required %b", err_sof, m_err); end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_full_frame();
        test_sof_error();
        test_idle_drop();
        test_reset_mid_row();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
